// File: rtl/sram_phase_sequencer_pkg.sv
// sram_phase_sequencer_pkg: shared state type, idle stage index and mask search helper
package sram_phase_sequencer_pkg;

    typedef enum logic [1:0] {S_IDLE, S_UART_RX, S_STAGE_RUN, S_STAGE_GAP} state_t;

    // Wide enough for up to 8 stages plus the all-ones "no stage" code
    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] ACTIVE_NONE = '1;

    // Lowest set bit of mask at index lo or above, ACTIVE_NONE when there is none
    function automatic logic [IDX_W-1:0] next_set_bit(input logic [7:0] mask, input logic [IDX_W-1:0] lo);
        logic [IDX_W-1:0] r;
        r = ACTIVE_NONE;
        for (int i = 7; i >= 0; i--)
            if (mask[i] && IDX_W'(i) >= lo) r = IDX_W'(i);
        return r;
    endfunction

endpackage

// File: rtl/sram_phase_sequencer_if.sv
// sram_phase_sequencer_if: stage start/done handshake and shared SRAM bus
interface sram_phase_sequencer_if #(
    parameter int NUM_STAGES = 2,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16
);
    logic [NUM_STAGES-1:0]        stage_start;
    logic [NUM_STAGES-1:0]        stage_done;
    logic [NUM_STAGES-1:0]        stage_we_n;
    logic [NUM_STAGES*ADDR_W-1:0] stage_address;
    logic [NUM_STAGES*DATA_W-1:0] stage_write_data;
    logic [ADDR_W-1:0]            SRAM_address;
    logic [DATA_W-1:0]            SRAM_write_data;
    logic                         SRAM_we_n;

    modport master (
        output stage_start, SRAM_address, SRAM_write_data, SRAM_we_n,
        input  stage_done, stage_we_n, stage_address, stage_write_data
    );

    modport slave (
        input  stage_start, SRAM_address, SRAM_write_data, SRAM_we_n,
        output stage_done, stage_we_n, stage_address, stage_write_data
    );
endinterface

// File: rtl/sram_phase_sequencer_client_mux.sv
// sram_client_mux: combinational N-client SRAM port selector, client 0 is the fallback
module sram_client_mux #(
    parameter int N      = 4,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int SW     = 2
) (
    input  logic [SW-1:0]       sel_i,
    input  logic [N*ADDR_W-1:0] addr_i,
    input  logic [N*DATA_W-1:0] wdata_i,
    input  logic [N-1:0]        we_n_i,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic                we_n_o
);
    // Pick the selected client's address, data and strobe
    always_comb begin
        addr_o  = addr_i[ADDR_W-1:0];
        wdata_o = wdata_i[DATA_W-1:0];
        we_n_o  = we_n_i[0];
        for (int i = 1; i < N; i++)
            if (sel_i == SW'(i)) begin
                addr_o  = addr_i[i*ADDR_W +: ADDR_W];
                wdata_o = wdata_i[i*DATA_W +: DATA_W];
                we_n_o  = we_n_i[i];
            end
    end
endmodule

// File: rtl/sram_phase_sequencer.sv
// sram_phase_sequencer: UART upload, masked stage chain with watchdog, SRAM arbitration
module sram_phase_sequencer
    import sram_phase_sequencer_pkg::*;
#(
    parameter int NUM_STAGES   = 2,
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int UART_TIMEOUT = 50000000,
    parameter int WDT_CYCLES   = 16777216,
    localparam int AW          = $clog2(NUM_STAGES) + 1
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  UART_RX_I,
    output logic                  uart_initialize,
    output logic                  uart_enable,
    input  logic [ADDR_W-1:0]     uart_address,
    input  logic [DATA_W-1:0]     uart_write_data,
    input  logic                  uart_we_n,
    output logic                  vga_enable,
    input  logic [ADDR_W-1:0]     vga_address,
    input  logic [NUM_STAGES-1:0] stage_mask,
    output logic [AW-1:0]         active_stage,
    output logic                  all_done,
    output logic [NUM_STAGES-1:0] stage_error,
    sram_phase_sequencer_if.master bus
);
    localparam int UW = UART_TIMEOUT > 1 ? $clog2(UART_TIMEOUT) : 1;
    localparam int WW = $clog2(WDT_CYCLES) + 1;
    localparam int SW = $clog2(NUM_STAGES + 2);

    state_t                state_q;
    logic [UW-1:0]         utmr_q;
    logic [WW-1:0]         wdt_q;
    logic [NUM_STAGES-1:0] mask_q, start_q, err_q;
    logic [AW-1:0]         idx_q;
    logic                  init_q, en_q, vga_q, done_q;

    logic [IDX_W-1:0] first_k, next_k;
    logic             hit, wdt_exp, gap;
    logic [SW-1:0]    sel;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_we_n;

    assign first_k = next_set_bit(8'(stage_mask), '0);
    assign next_k  = next_set_bit(8'(mask_q), IDX_W'(idx_q) + IDX_W'(1));
    // start_q is one-hot on the running stage, so done from other stages is masked out
    assign hit     = |(bus.stage_done & start_q);
    assign wdt_exp = (WDT_CYCLES != 0) && (wdt_q == WW'(WDT_CYCLES - 1));

    // Sequencer FSM with registered handshake outputs and timers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            utmr_q  <= '0;
            wdt_q   <= '0;
            mask_q  <= '0;
            start_q <= '0;
            err_q   <= '0;
            idx_q   <= '0;
            init_q  <= 1'b0;
            en_q    <= 1'b0;
            vga_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            init_q <= 1'b0;
            en_q   <= init_q;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (!UART_RX_I) begin
                    init_q  <= 1'b1;
                    utmr_q  <= '0;
                    vga_q   <= 1'b0;
                    state_q <= S_UART_RX;
                end
                S_UART_RX: if (utmr_q == UW'(UART_TIMEOUT - 1)) begin
                    utmr_q <= '0;
                    mask_q <= stage_mask;
                    if (first_k == ACTIVE_NONE) begin
                        done_q  <= 1'b1;
                        vga_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        start_q <= NUM_STAGES'(1) << first_k;
                        idx_q   <= AW'(first_k);
                        state_q <= S_STAGE_RUN;
                    end
                end else
                    utmr_q <= !uart_we_n ? '0 : utmr_q + 1'b1;
                S_STAGE_RUN: if (hit) begin
                    start_q <= '0;
                    wdt_q   <= '0;
                    if (next_k == ACTIVE_NONE) begin
                        done_q  <= 1'b1;
                        vga_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else
                        state_q <= S_STAGE_GAP;
                end else if (wdt_exp) begin
                    start_q <= '0;
                    wdt_q   <= '0;
                    err_q   <= err_q | start_q;
                    vga_q   <= 1'b1;
                    state_q <= S_IDLE;
                end else
                    wdt_q <= wdt_q + 1'b1;
                default: begin
                    start_q <= NUM_STAGES'(1) << next_k;
                    idx_q   <= AW'(next_k);
                    state_q <= S_STAGE_RUN;
                end
            endcase
        end
    end

    assign uart_initialize = init_q;
    assign uart_enable     = en_q;
    assign vga_enable      = vga_q;
    assign all_done        = done_q;
    assign stage_error     = err_q;
    assign bus.stage_start = start_q;
    assign active_stage    = state_q == S_STAGE_RUN ? idx_q : AW'(ACTIVE_NONE);

    // Client 0 = VGA, 1 = UART, 2.. = stages; the gap keeps the previous stage address
    assign gap = state_q == S_STAGE_GAP;
    assign sel = state_q == S_IDLE ? SW'(0) : state_q == S_UART_RX ? SW'(1) : SW'(idx_q) + SW'(2);

    sram_client_mux #(.N(NUM_STAGES + 2), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SW(SW)) u_mux (
        .sel_i   (sel),
        .addr_i  ({bus.stage_address, uart_address, vga_address}),
        .wdata_i ({bus.stage_write_data, uart_write_data, uart_write_data}),
        .we_n_i  ({bus.stage_we_n, uart_we_n, 1'b1}),
        .addr_o  (m_addr),
        .wdata_o (m_wdata),
        .we_n_o  (m_we_n)
    );

    assign bus.SRAM_address    = m_addr;
    assign bus.SRAM_write_data = gap ? uart_write_data : m_wdata;
    assign bus.SRAM_we_n       = gap | m_we_n;
endmodule

// File: tb/tb_sram_phase_sequencer.sv
// tb_sram_phase_sequencer: randomized uploads and stage chains checked by an event scoreboard
module tb_sram_phase_sequencer;
    localparam int N = 3, AW = 18, DW = 16, TO = 100, WDT = 50, NEVER = 1000;
    localparam int K_INIT = 0, K_EN = 1, K_START = 2, K_STOP = 3, K_DONE = 4;

    typedef struct {int kind; int stage; int cyc;} ev_t;

    logic          clk = 0, Resetn = 0, UART_RX_I = 1, uart_we_n = 1;
    logic          uart_initialize, uart_enable, vga_enable, all_done;
    logic [AW-1:0] uart_address = '0, vga_address = '0;
    logic [DW-1:0] uart_write_data = '0;
    logic [N-1:0]  stage_mask = '0, stage_error, err_m = '0;
    logic [2:0]    active_stage;

    int   checks = 0, errors = 0, cyc = 0;
    int   lat[N];
    bit   quiet = 1, spur = 0;
    ev_t  q[$];

    sram_phase_sequencer_if #(.NUM_STAGES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_phase_sequencer #(.NUM_STAGES(N), .ADDR_W(AW), .DATA_W(DW), .UART_TIMEOUT(TO), .WDT_CYCLES(WDT)) dut (
        .Clock(clk), .Resetn(Resetn), .UART_RX_I(UART_RX_I),
        .uart_initialize(uart_initialize), .uart_enable(uart_enable),
        .uart_address(uart_address), .uart_write_data(uart_write_data), .uart_we_n(uart_we_n),
        .vga_enable(vga_enable), .vga_address(vga_address), .stage_mask(stage_mask),
        .active_stage(active_stage), .all_done(all_done), .stage_error(stage_error), .bus(bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input bit ok, input string nm, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic void push(input int kind, input int stage, input int c);
        ev_t e;
        e.kind = kind; e.stage = stage; e.cyc = c;
        q.push_back(e);
    endfunction

    // Expected chain: stages in ascending mask order, next start one idle cycle after done,
    // a stage that is not done within WDT cycles is dropped and flagged
    function automatic void plan(input logic [N-1:0] m, input int t0);
        int t = t0, last = t0;
        bit ab = 0;
        for (int k = 0; k < N && !ab; k++)
            if (m[k]) begin
                push(K_START, k, t);
                if (lat[k] <= WDT) begin
                    last = t + lat[k];
                    push(K_STOP, k, last);
                    t = last + 1;
                end else begin
                    push(K_STOP, k, t + WDT);
                    err_m = err_m | (N'(1) << k);
                    ab = 1;
                end
            end
        if (!ab) push(K_DONE, 0, last);
    endfunction

    task automatic exp_ev(input int kind, input int stage);
        ev_t e;
        if (q.size() == 0) begin
            chk(0, "unexpected_event", kind * 10 + stage, -1);
            return;
        end
        e = q.pop_front();
        chk(e.kind == kind && e.stage == stage, "event_kind", kind * 10 + stage, e.kind * 10 + e.stage);
        chk(e.cyc == cyc, "event_cycle", cyc, e.cyc);
    endtask

    task automatic upload(input logic [N-1:0] m, input int nw, input int gap, input bit wait_end);
        int lc, b;
        stage_mask = m;
        @(negedge clk);
        UART_RX_I = 0;
        lc = cyc + 1;
        push(K_INIT, 0, lc);
        push(K_EN, 0, lc + 1);
        @(negedge clk);
        UART_RX_I = 1;
        for (int w = 0; w < nw; w++) begin
            repeat (gap - 1) @(negedge clk);
            uart_address    = AW'($urandom);
            uart_write_data = DW'($urandom);
            uart_we_n       = 0;
            lc = cyc + 1;
            #1;
            chk(bus.SRAM_address == uart_address, "uart_addr", bus.SRAM_address, uart_address);
            chk(bus.SRAM_write_data == uart_write_data, "uart_data", bus.SRAM_write_data, uart_write_data);
            chk(bus.SRAM_we_n == 0, "uart_we_n", bus.SRAM_we_n, 0);
            chk(vga_enable == 0, "vga_off", vga_enable, 0);
            @(negedge clk);
            uart_we_n = 1;
        end
        plan(m, lc + TO);
        if (!wait_end) return;
        b = 0;
        while (q.size() > 0 && b < 3000) begin
            @(negedge clk);
            b++;
        end
        if (q.size() > 0) begin
            chk(0, "event_timeout", q.size(), 0);
            q.delete();
        end
        repeat (3) @(negedge clk);
        #2;
        chk(stage_error == err_m, "stage_error", stage_error, err_m);
        chk(vga_enable == 1, "vga_idle", vga_enable, 1);
        chk(active_stage == 3'b111, "active_idle", active_stage, 7);
    endtask

    // Stage models: done pulses lat[k] cycles into start; optional stray done on stage 2
    initial begin
        int cnt[N];
        logic [N-1:0] d;
        cnt = '{default: 0};
        bus.stage_done = '0;
        forever begin
            @(negedge clk);
            d = '0;
            for (int k = 0; k < N; k++) begin
                cnt[k] = bus.stage_start[k] ? cnt[k] + 1 : 0;
                d[k] = cnt[k] == lat[k];
            end
            if (spur && cnt[0] == 5) d[2] = 1'b1;
            bus.stage_done = d;
        end
    end

    // Monitor: turn DUT output activity into events and check bus invariants each cycle
    initial begin
        logic [N-1:0] ps = '0, s;
        int k1;
        forever begin
            @(negedge clk);
            #1;
            s = bus.stage_start;
            if (!quiet) begin
                for (int k = 0; k < N; k++)
                    if (ps[k] && !s[k]) begin
                        exp_ev(K_STOP, k);
                        if (q.size() > 0 && q[0].kind == K_START)
                            chk(bus.SRAM_address == bus.stage_address[k*AW +: AW], "gap_addr",
                                bus.SRAM_address, bus.stage_address[k*AW +: AW]);
                    end
                for (int k = 0; k < N; k++)
                    if (!ps[k] && s[k]) exp_ev(K_START, k);
                if (uart_initialize) exp_ev(K_INIT, 0);
                if (uart_enable) exp_ev(K_EN, 0);
                if (all_done) exp_ev(K_DONE, 0);
                chk($countones(s) <= 1, "start_onehot", s, 0);
                if (s != 0) begin
                    k1 = 0;
                    for (int k = 0; k < N; k++) if (s[k]) k1 = k;
                    chk(active_stage == 3'(k1), "active_stage", active_stage, k1);
                    chk(bus.SRAM_address == bus.stage_address[k1*AW +: AW], "stage_addr",
                        bus.SRAM_address, bus.stage_address[k1*AW +: AW]);
                    chk(bus.SRAM_write_data == bus.stage_write_data[k1*DW +: DW], "stage_data",
                        bus.SRAM_write_data, bus.stage_write_data[k1*DW +: DW]);
                    chk(bus.SRAM_we_n == 0, "stage_we_n", bus.SRAM_we_n, 0);
                end else begin
                    chk(active_stage == 3'b111, "active_none", active_stage, 7);
                    if (uart_we_n) chk(bus.SRAM_we_n == 1, "idle_we_n", bus.SRAM_we_n, 1);
                end
            end
            ps = s;
        end
    end

    initial begin
        int b;
        lat = '{10, 10, 10};
        for (int k = 0; k < N; k++) begin
            bus.stage_address[k*AW +: AW]    = AW'($urandom);
            bus.stage_write_data[k*DW +: DW] = DW'($urandom);
        end
        bus.stage_we_n = '0;
        vga_address = AW'($urandom);
        repeat (3) @(negedge clk);
        #1;
        chk(vga_enable == 1, "rst_vga", vga_enable, 1);
        chk(bus.stage_start == 0, "rst_start", bus.stage_start, 0);
        chk(uart_initialize == 0 && uart_enable == 0, "rst_uart", {uart_initialize, uart_enable}, 0);
        chk(all_done == 0, "rst_done", all_done, 0);
        chk(stage_error == 0, "rst_err", stage_error, 0);
        chk(active_stage == 3'b111, "rst_active", active_stage, 7);
        chk(bus.SRAM_we_n == 1, "rst_we_n", bus.SRAM_we_n, 1);
        chk(bus.SRAM_address == vga_address, "rst_vga_addr", bus.SRAM_address, vga_address);
        @(negedge clk);
        Resetn = 1;
        @(negedge clk);
        #2 quiet = 0;

        upload(3'b111, 10, 20, 1);
        upload(3'b101, 2, 7, 1);
        upload(3'b000, 0, 5, 1);
        lat[1] = NEVER;
        upload(3'b111, 1, 5, 1);
        lat[1] = 10;
        upload(3'b111, 1, 5, 1);
        lat[0] = WDT;
        lat[1] = $urandom_range(1, 20);
        spur = 1;
        upload(3'b011, 1, 5, 1);
        spur = 0;
        lat[0] = WDT + 1;
        upload(3'b001, 0, 5, 1);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++)
                lat[k] = $urandom_range(0, 9) == 0 ? NEVER : $urandom_range(1, WDT + 10);
            upload(N'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(2, 30), 1);
        end

        lat = '{30, 30, 30};
        upload(3'b111, 1, 5, 0);
        b = 0;
        while (bus.stage_start == 0 && b < 500) begin
            @(negedge clk);
            b++;
        end
        chk(bus.stage_start != 0, "run_reached", bus.stage_start, 1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        quiet = 1;
        Resetn = 0;
        #1;
        chk(bus.stage_start == 0, "mid_rst_start", bus.stage_start, 0);
        chk(vga_enable == 1, "mid_rst_vga", vga_enable, 1);
        chk(stage_error == 0, "mid_rst_err", stage_error, 0);
        chk(active_stage == 3'b111, "mid_rst_active", active_stage, 7);
        q.delete();
        err_m = '0;
        @(negedge clk);
        Resetn = 1;
        @(negedge clk);
        #2 quiet = 0;
        lat = '{10, 4, 7};
        upload(3'b110, 1, 5, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_phase_sequencer.md
Name: sram_phase_sequencer

Overview:
- Parametrised top-level sequencer and SRAM bus multiplexer for the decompression datapath.
- After a UART image upload, runs a configurable chain of NUM_STAGES decode stages in order, using a start/done handshake with each stage.
- Grants the shared SRAM port to the VGA reader, the UART writer or exactly one active stage.
- Adds a per-run stage-skip mask, a per-stage watchdog with sticky error reporting, and a completion pulse.

Parameters:
NUM_STAGES, 2, number of decode stages in the chain (1..8)
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width
UART_TIMEOUT, 50000000, idle cycles on UART writes that end the upload
WDT_CYCLES, 16777216, max cycles a stage may hold start before abort; 0 disables the watchdog

Ports:
Clock  in  1  system clock (50 MHz)
Resetn  in  1  asynchronous reset, active-low
UART_RX_I  in  1  raw UART line; low in IDLE marks a start bit
uart_initialize  out  1  one-cycle pulse on entry to S_UART_RX
uart_enable  out  1  one-cycle pulse in the cycle after uart_initialize
uart_address  in  ADDR_W  UART writer address
uart_write_data  in  DATA_W  UART writer data
uart_we_n  in  1  UART writer write strobe, active-low
vga_enable  out  1  VGA reader enable
vga_address  in  ADDR_W  VGA reader address
stage_mask  in  NUM_STAGES  1 = run stage k; latched at upload timeout
stage_start  out  NUM_STAGES  level start to stage k; at most one bit high
stage_done  in  NUM_STAGES  done from stage k
stage_address  in  NUM_STAGES x ADDR_W  packed per-stage addresses
stage_write_data  in  NUM_STAGES x DATA_W  packed per-stage write data
stage_we_n  in  NUM_STAGES  per-stage write strobe, active-low
SRAM_address  out  ADDR_W  muxed address to SRAM controller
SRAM_write_data  out  DATA_W  muxed write data
SRAM_we_n  out  1  muxed write strobe
active_stage  out  clog2(NUM_STAGES)+1  index of the running stage; all-ones when no stage is running
all_done  out  1  one-cycle pulse when the chain completes without abort
stage_error  out  NUM_STAGES  sticky watchdog-abort flags

Behaviour:
- Reset values:
  - state = S_IDLE, vga_enable = 1.
  - uart_initialize, uart_enable, stage_start, all_done and stage_error all 0.
  - All timers 0; latched mask 0.
- Reset mid-operation returns to these values immediately. Any running stage sees start drop asynchronously.
- States: S_IDLE, S_UART_RX, S_STAGE_RUN, S_STAGE_GAP.
- S_IDLE:
  - vga_enable = 1.
  - On UART_RX_I = 0: pulse uart_initialize, clear upload timer, set vga_enable = 0, go to S_UART_RX.
- S_UART_RX:
  - uart_enable pulses exactly one cycle after uart_initialize.
  - Upload timer increments every cycle and clears on any cycle with uart_we_n = 0.
  - When the timer equals UART_TIMEOUT-1: latch stage_mask, clear the timer, then select the lowest set bit k.
  - If k exists: stage_start[k] = 1, go to S_STAGE_RUN.
  - If the mask is all-zero: pulse all_done, go to S_IDLE.
- S_STAGE_RUN:
  - stage_start[k] is held high and the watchdog counter increments.
  - On stage_done[k] = 1: drop start, clear the watchdog, find the next latched-mask bit above k.
    - Next bit found: go to S_STAGE_GAP.
    - No next bit: pulse all_done, go to S_IDLE.
  - Watchdog abort: when WDT_CYCLES != 0 and the counter equals WDT_CYCLES-1 with no done, drop start, set stage_error[k], go to S_IDLE. No all_done pulse.
  - Simultaneous done and watchdog expiry: done wins and no error is set.
  - stage_done bits of non-active stages are ignored.
- S_STAGE_GAP: exactly one cycle with all starts low, so every stage sees a rising edge. Then assert start for the next stage and go to S_STAGE_RUN.
- UART_RX_I activity outside S_IDLE is ignored.
- stage_error clears only on reset.
- SRAM mux is combinational from state and the registered stage index:
  - S_IDLE: vga_address, we_n = 1.
  - S_UART_RX: the three UART signals.
  - S_STAGE_RUN: stage k signals.
  - S_STAGE_GAP: previous stage address, we_n forced to 1.
- Write data defaults to uart_write_data whenever not otherwise selected.
- Latencies:
  - Start-bit detection to uart_initialize: 1 cycle.
  - stage_done to next start: 2 cycles.
  - stage_done of the last stage to all_done: 1 cycle.
- Timer widths: $clog2(UART_TIMEOUT) and $clog2(WDT_CYCLES)+1. Counters never wrap in normal operation.

Decomposition:
- Shared package holds:
  - the state enum type,
  - the localparam ACTIVE_NONE (all-ones),
  - a function next_set_bit(mask, from) returning the index or ACTIVE_NONE.
- One sub-module, sram_client_mux: the parametrised combinational N-client SRAM selector. It keeps the sequencer FSM separate from the datapath mux.

Test Plan (NUM_STAGES=3, UART_TIMEOUT=100, WDT_CYCLES=50):
1. UART_RX_I falls in IDLE -> uart_initialize high the next cycle, uart_enable the cycle after, vga_enable 0. Drive uart_we_n low every 20 cycles for 10 writes -> SRAM_address tracks uart_address; timeout fires 100 cycles after the last write.
2. Mask 3'b111; each stage asserts done 10 cycles after start -> stage_start one-hot 001, 010, 100 with a 1-cycle all-low gap; active_stage 0,1,2; all_done pulses once; return to IDLE with vga_enable 1.
3. Mask 3'b101 -> stage 1 never started. Mask 3'b000 -> all_done the cycle after timeout, no start asserted.
4. Stage 1 never asserts done -> start drops after 50 cycles; stage_error = 3'b010; no all_done. A following upload with stage 1 answering keeps stage_error = 010.
5. Stage 0 done arrives on the watchdog-expiry cycle -> no error, stage 1 starts; stage_done[2] pulsed while stage 0 runs -> ignored.
6. Resetn low during S_STAGE_RUN -> all starts 0 immediately, vga_enable 1, stage_error 0; SRAM_we_n 1 during every gap cycle.
